fpdivsqrt_req_queue: RTL and testbench
======================================

FPDIVSQRT_REQ_QUEUE -- requirements
Module: fpdivsqrt_req_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the request FIFO depth; legal values are powers of 2, at least 2.
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the request tag width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 req_valid_i / req_ready_o  in / out  1 each  upstream request handshake.
REQ-006 req_fp_format_i  in  2  request format (0=f16, 1=f32, 2=f64).
REQ-007 req_is_fdiv_i  in  1  request operation select (1=div, 0=sqrt).
REQ-008 req_rm_i  in  3  request rounding mode.
REQ-009 req_opa_i, req_opb_i  in  64 each  request operands.
REQ-010 req_tag_i  in  TAG_W  request ID.
REQ-011 flush_i  in  1  kill all queued and in-flight work.
REQ-012 div_start_valid_o / div_start_ready_i  out / in  1 each  divider start handshake.
REQ-013 div_fp_format_o, div_is_fdiv_o, div_rm_o, div_opa_o, div_opb_o  out  2 / 1 / 3 / 64 / 64  operation fields to the divider.
REQ-014 div_flush_o  out  1  flush to the divider.
REQ-015 div_finish_valid_i / div_finish_ready_o  in / out  1 each  divider result handshake.
REQ-016 div_res_i  in  64  divider result.
REQ-017 div_fflags_i  in  5  divider exception flags.
REQ-018 rsp_valid_o / rsp_ready_i  out / in  1 each  downstream response handshake.
REQ-019 rsp_res_o  out  64  response result.
REQ-020 rsp_fflags_o  out  5  response exception flags.
REQ-021 rsp_tag_o  out  TAG_W  response tag.
REQ-022 count_o  out  log2(DEPTH)+1  number of occupied FIFO entries.
REQ-023 busy_o  out  1  FIFO non-empty or an operation is in flight.

Function
REQ-024 The FIFO SHALL store {fp_format, is_fdiv, rm, opa, opb, tag}, using read and write pointers of log2(DEPTH)+1 bits each; pointers wrap modulo 2*DEPTH.
- full: pointer MSBs differ and the remaining bits are equal.
- empty: pointers are equal.
REQ-025 req_ready_o SHALL equal ~full & ~flush_i, with no same-cycle bypass; when full, a pop does not free a slot until the next cycle.
REQ-026 An enqueue SHALL occur on req_valid_i & req_ready_o; count_o SHALL update one cycle later.
REQ-027 The issue FSM SHALL have two states, IDLE and WAIT.
REQ-028 In IDLE, div_start_valid_o SHALL equal ~empty & ~flush_i, and the div_* operation fields SHALL be driven combinationally from the FIFO head.
REQ-029 On div_start_valid_o & div_start_ready_i, the block SHALL pop the head, latch the head tag into inflight_tag, and go to WAIT.
REQ-030 In WAIT, div_start_valid_o SHALL be 0, and the response path SHALL pass through:
- rsp_valid_o = div_finish_valid_i & ~flush_i;
- div_finish_ready_o = rsp_ready_i;
- rsp_res_o = div_res_i, rsp_fflags_o = div_fflags_i;
- rsp_tag_o = inflight_tag.
REQ-031 On div_finish_valid_i & rsp_ready_i in WAIT, the FSM SHALL return to IDLE; at most one operation is in flight.
REQ-032 In IDLE, rsp_valid_o and div_finish_ready_o SHALL be 0.
REQ-033 Latency: a request enqueued at edge N into an empty FIFO with the FSM in IDLE SHALL present div_start_valid_o=1 after edge N.
REQ-034 Back-to-back issue: after a finish handshake at edge M, the next start_valid SHALL assert after edge M, with no idle cycle.
REQ-035 Simultaneous enqueue and pop SHALL leave count_o unchanged and advance both pointers.
REQ-036 flush_i, in the cycle it is asserted:
- resets both pointers;
- forces the FSM to IDLE;
- drops any concurrent request;
- forces rsp_valid_o=0 and div_start_valid_o=0.
REQ-037 div_flush_o SHALL equal flush_i & (state==WAIT).
REQ-038 busy_o SHALL equal ~empty | (state==WAIT).

Reset
REQ-039 While rst_n=0, the block SHALL hold: state=IDLE, pointers=0, inflight_tag=0, count_o=0, busy_o=0, req_ready_o=1, div_start_valid_o=0, div_finish_ready_o=0, rsp_valid_o=0, div_flush_o=0.
REQ-040 Reset asserted mid-operation SHALL discard all queued and in-flight state immediately, without waiting for a clock edge.

Verification
REQ-041 Single op: enqueue f64 div tag=3, opa=0x4000000000000000, opb=0x3FF0000000000000 -> start_valid high the next cycle; after the finish handshake, rsp_tag_o=3 and rsp_res_o=div_res_i.
REQ-042 Fill: 4 enqueues with div_start_ready_i=0 -> count_o=4, req_ready_o=0; a 5th request stalls until a pop, then is accepted the cycle after.
REQ-043 Ordering: tags 0..7 with random start/finish/rsp_ready delays (0-7 cycles) -> responses emerge in tag order 0..7 and never two in flight.
REQ-044 Backpressure: rsp_ready_i=0 for 5 cycles while div_finish_valid_i=1 -> div_finish_ready_o=0, state stays WAIT, rsp fields stable.
REQ-045 Flush: 3 queued plus 1 in flight, pulse flush_i -> div_flush_o=1 for that cycle, count_o=0 and busy_o=0 next cycle, no response emitted.
REQ-046 Async reset asserted mid-WAIT between clock edges -> all outputs reach their REQ-039 values before the next edge.

Source files
------------

// File: rtl/fpdivsqrt_req_queue.sv
// Request FIFO and single-outstanding issue controller for an FP divide/sqrt unit.
// Requests are queued, issued one at a time, and responses are tagged with the issuing request ID.
module fpdivsqrt_req_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_fp_format_i,
    input  logic                     req_is_fdiv_i,
    input  logic [2:0]               req_rm_i,
    input  logic [63:0]              req_opa_i,
    input  logic [63:0]              req_opb_i,
    input  logic [TAG_W-1:0]         req_tag_i,

    input  logic                     flush_i,

    output logic                     div_start_valid_o,
    input  logic                     div_start_ready_i,
    output logic [1:0]               div_fp_format_o,
    output logic                     div_is_fdiv_o,
    output logic [2:0]               div_rm_o,
    output logic [63:0]              div_opa_o,
    output logic [63:0]              div_opb_o,
    output logic                     div_flush_o,

    input  logic                     div_finish_valid_i,
    output logic                     div_finish_ready_o,
    input  logic [63:0]              div_res_i,
    input  logic [4:0]               div_fflags_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [63:0]              rsp_res_o,
    output logic [4:0]               rsp_fflags_o,
    output logic [TAG_W-1:0]         rsp_tag_o,

    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    typedef struct packed {
        logic [1:0]       fp_format;
        logic             is_fdiv;
        logic [2:0]       rm;
        logic [63:0]      opa;
        logic [63:0]      opb;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    entry_t             head;

    state_e             state_q, state_d;
    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic [TAG_W-1:0]   inflight_tag_q, inflight_tag_d;

    logic               full, empty, in_wait;
    logic               push, start_fire, finish_fire;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign in_wait = (state_q == S_WAIT);

    assign req_ready_o = ~full & ~flush_i;
    assign push        = req_valid_i & req_ready_o;

    assign wr_entry = '{fp_format: req_fp_format_i, is_fdiv: req_is_fdiv_i, rm: req_rm_i,
                        opa: req_opa_i, opb: req_opb_i, tag: req_tag_i};
    assign head     = mem_q[rptr_q[AW-1:0]];

    assign div_start_valid_o = ~in_wait & ~empty & ~flush_i;
    assign div_fp_format_o   = head.fp_format;
    assign div_is_fdiv_o     = head.is_fdiv;
    assign div_rm_o          = head.rm;
    assign div_opa_o         = head.opa;
    assign div_opb_o         = head.opb;
    assign div_flush_o       = flush_i & in_wait;

    assign start_fire  = div_start_valid_o & div_start_ready_i;
    assign finish_fire = in_wait & div_finish_valid_i & rsp_ready_i;

    assign rsp_valid_o        = in_wait & div_finish_valid_i & ~flush_i;
    assign div_finish_ready_o = in_wait & rsp_ready_i;
    assign rsp_res_o          = div_res_i;
    assign rsp_fflags_o       = div_fflags_i;
    assign rsp_tag_o          = inflight_tag_q;

    assign count_o = wptr_q - rptr_q;
    assign busy_o  = ~empty | in_wait;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d        = state_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        inflight_tag_d = inflight_tag_q;
        if (flush_i) begin
            state_d = S_IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (start_fire) begin
                rptr_d         = rptr_q + PTR_ONE;
                inflight_tag_d = head.tag;
                state_d        = S_WAIT;
            end else if (finish_fire) begin
                state_d = S_IDLE;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wptr_q         <= '0;
            rptr_q         <= '0;
            inflight_tag_q <= '0;
        end else begin
            state_q        <= state_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            inflight_tag_q <= inflight_tag_d;
        end
    end

    // NOTE: payload storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_fpdivsqrt_req_queue.sv
// Self-checking bench for fpdivsqrt_req_queue: directed steps plus randomized traffic,
// compared every cycle against a queue-based model of accepted requests and the in-flight op.
module tb_fpdivsqrt_req_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [1:0]         req_fp_format_i;
    logic               req_is_fdiv_i;
    logic [2:0]         req_rm_i;
    logic [63:0]        req_opa_i;
    logic [63:0]        req_opb_i;
    logic [TAG_W-1:0]   req_tag_i;
    logic               flush_i;
    logic               div_start_valid_o;
    logic               div_start_ready_i;
    logic [1:0]         div_fp_format_o;
    logic               div_is_fdiv_o;
    logic [2:0]         div_rm_o;
    logic [63:0]        div_opa_o;
    logic [63:0]        div_opb_o;
    logic               div_flush_o;
    logic               div_finish_valid_i;
    logic               div_finish_ready_o;
    logic [63:0]        div_res_i;
    logic [4:0]         div_fflags_i;
    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [63:0]        rsp_res_o;
    logic [4:0]         rsp_fflags_o;
    logic [TAG_W-1:0]   rsp_tag_o;
    logic [2:0]         count_o;
    logic               busy_o;

    fpdivsqrt_req_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_fp_format_i    (req_fp_format_i),
        .req_is_fdiv_i      (req_is_fdiv_i),
        .req_rm_i           (req_rm_i),
        .req_opa_i          (req_opa_i),
        .req_opb_i          (req_opb_i),
        .req_tag_i          (req_tag_i),
        .flush_i            (flush_i),
        .div_start_valid_o  (div_start_valid_o),
        .div_start_ready_i  (div_start_ready_i),
        .div_fp_format_o    (div_fp_format_o),
        .div_is_fdiv_o      (div_is_fdiv_o),
        .div_rm_o           (div_rm_o),
        .div_opa_o          (div_opa_o),
        .div_opb_o          (div_opb_o),
        .div_flush_o        (div_flush_o),
        .div_finish_valid_i (div_finish_valid_i),
        .div_finish_ready_o (div_finish_ready_o),
        .div_res_i          (div_res_i),
        .div_fflags_i       (div_fflags_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_res_o          (rsp_res_o),
        .rsp_fflags_o       (rsp_fflags_o),
        .rsp_tag_o          (rsp_tag_o),
        .count_o            (count_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       fmt;
        logic             is_fdiv;
        logic [2:0]       rm;
        logic [63:0]      opa;
        logic [63:0]      opb;
        logic [TAG_W-1:0] tag;
    } req_t;

    // Model: requests accepted but not yet issued, plus the single op at the divider.
    req_t   mq[$];
    req_t   inflight_req;
    bit     inflight;
    int     got_q[$];
    bit     last_accept, last_fire_s, last_fire_f;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int tag);
        req_fp_format_i = 2'($urandom_range(0, 2));
        req_is_fdiv_i   = 1'($urandom_range(0, 1));
        req_rm_i        = 3'($urandom_range(0, 4));
        req_opa_i       = {$urandom, $urandom};
        req_opb_i       = {$urandom, $urandom};
        req_tag_i       = TAG_W'(tag);
    endtask

    // Called just after a rising edge with inputs driven: checks outputs, clocks once, updates model.
    task automatic step();
        bit   exp_ready, exp_sv, exp_rv, fire_s, fire_f, accept;
        req_t cur;
        #1;
        exp_ready = (mq.size() < DEPTH) && !flush_i;
        exp_sv    = !inflight && (mq.size() != 0) && !flush_i;
        exp_rv    = inflight && div_finish_valid_i && !flush_i;
        chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
        chk("start_valid", 64'(div_start_valid_o), 64'(exp_sv));
        chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
        chk("finish_ready", 64'(div_finish_ready_o), 64'(inflight && rsp_ready_i));
        chk("div_flush", 64'(div_flush_o), 64'(flush_i && inflight));
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("busy", 64'(busy_o), 64'((mq.size() != 0) || inflight));
        if (exp_sv) begin
            chk("div_fmt", 64'(div_fp_format_o), 64'(mq[0].fmt));
            chk("div_is_fdiv", 64'(div_is_fdiv_o), 64'(mq[0].is_fdiv));
            chk("div_rm", 64'(div_rm_o), 64'(mq[0].rm));
            chk("div_opa", div_opa_o, mq[0].opa);
            chk("div_opb", div_opb_o, mq[0].opb);
        end
        if (exp_rv) begin
            chk("rsp_tag", 64'(rsp_tag_o), 64'(inflight_req.tag));
            chk("rsp_res", rsp_res_o, div_res_i);
            chk("rsp_fflags", 64'(rsp_fflags_o), 64'(div_fflags_i));
        end
        fire_s = exp_sv && div_start_ready_i;
        fire_f = inflight && div_finish_valid_i && rsp_ready_i;
        accept = req_valid_i && exp_ready;
        cur = '{fmt: req_fp_format_i, is_fdiv: req_is_fdiv_i, rm: req_rm_i,
                opa: req_opa_i, opb: req_opb_i, tag: req_tag_i};
        last_accept = 1'b0;
        last_fire_s = 1'b0;
        last_fire_f = 1'b0;
        @(posedge clk);
        if (flush_i) begin
            mq.delete();
            inflight = 1'b0;
        end else begin
            if (fire_f) begin
                got_q.push_back(int'(inflight_req.tag));
                inflight    = 1'b0;
                last_fire_f = 1'b1;
            end
            if (fire_s) begin
                inflight_req = mq.pop_front();
                inflight     = 1'b1;
                last_fire_s  = 1'b1;
            end
            if (accept) begin
                mq.push_back(cur);
                last_accept = 1'b1;
            end
        end
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_req_ready", 64'(req_ready_o), 64'(1));
        chk("rst_start_valid", 64'(div_start_valid_o), 64'(0));
        chk("rst_finish_ready", 64'(div_finish_ready_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_div_flush", 64'(div_flush_o), 64'(0));
    endtask

    task automatic drain();
        int n = 0;
        req_valid_i = 1'b0;
        while (((mq.size() != 0) || inflight) && (n < 100)) begin
            div_start_ready_i  = 1'b1;
            div_finish_valid_i = inflight;
            rsp_ready_i        = 1'b1;
            div_res_i          = {$urandom, $urandom};
            div_fflags_i       = 5'($urandom);
            step();
            n++;
        end
        chk("drain_done", 64'(n < 100), 64'(1));
        div_start_ready_i  = 1'b0;
        div_finish_valid_i = 1'b0;
    endtask

    initial begin
        logic [63:0] held_res;
        int          sd, fd, rd, send, ncyc, base;

        rst_n = 1'b0;
        req_valid_i = 1'b0;
        set_req(0);
        flush_i = 1'b0;
        div_start_ready_i = 1'b0;
        div_finish_valid_i = 1'b0;
        div_res_i = '0;
        div_fflags_i = '0;
        rsp_ready_i = 1'b1;
        inflight = 1'b0;

        #3;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single f64 divide with tag 3.
        set_req(3);
        req_fp_format_i = 2'd2;
        req_is_fdiv_i   = 1'b1;
        req_opa_i       = 64'h4000000000000000;
        req_opb_i       = 64'h3FF0000000000000;
        req_valid_i     = 1'b1;
        step();
        req_valid_i = 1'b0;
        chk("single_start_valid", 64'(div_start_valid_o), 64'(1));
        chk("single_opa", div_opa_o, 64'h4000000000000000);
        div_start_ready_i = 1'b1;
        step();
        div_start_ready_i  = 1'b0;
        div_finish_valid_i = 1'b1;
        rsp_ready_i        = 1'b1;
        div_res_i          = 64'h4000000000000000;
        div_fflags_i       = 5'h01;
        #1;
        chk("single_rsp_tag", 64'(rsp_tag_o), 64'(3));
        chk("single_rsp_res", rsp_res_o, 64'h4000000000000000);
        step();
        div_finish_valid_i = 1'b0;
        step();

        // Fill to capacity; a fifth request stalls until a pop frees a slot.
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(4 + i);
            req_valid_i = 1'b1;
            step();
        end
        chk("fill_count", 64'(count_o), 64'(4));
        chk("fill_ready", 64'(req_ready_o), 64'(0));
        set_req(9);
        step();
        div_start_ready_i = 1'b1;
        step();
        div_start_ready_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        chk("fill_fifth_count", 64'(count_o), 64'(4));
        drain();
        chk("fill_rsp_count", 64'(got_q.size()), 64'(5));
        if (got_q.size() == 5) begin
            chk("fill_rsp_first", 64'(got_q[0]), 64'(4));
            chk("fill_rsp_last", 64'(got_q[4]), 64'(9));
        end

        // Randomized ordering with 0-7 cycle delays on every handshake.
        got_q.delete();
        send = 0;
        ncyc = 0;
        sd = $urandom_range(0, 7);
        fd = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        while ((got_q.size() < 8) && (ncyc < 800)) begin
            req_valid_i = (send < 8) && ($urandom_range(0, 3) != 0);
            set_req(send);
            div_start_ready_i  = (sd == 0);
            div_finish_valid_i = inflight && (fd == 0);
            rsp_ready_i        = (rd == 0);
            div_res_i          = {$urandom, $urandom};
            div_fflags_i       = 5'($urandom);
            if (inflight) chk("one_in_flight", 64'(div_start_valid_o), 64'(0));
            step();
            if (last_accept) send++;
            if (last_fire_s) begin
                sd = $urandom_range(0, 7);
                fd = $urandom_range(0, 7);
            end else begin
                if (sd > 0) sd--;
                if (fd > 0) fd--;
            end
            if (last_fire_f) rd = $urandom_range(0, 7);
            else if (rd > 0) rd--;
            ncyc++;
        end
        chk("order_rsp_count", 64'(got_q.size()), 64'(8));
        foreach (got_q[i]) chk("order_tag", 64'(got_q[i]), 64'(i));
        req_valid_i = 1'b0;
        drain();

        // Backpressure: result offered but downstream stalled for 5 cycles.
        set_req(5);
        req_valid_i = 1'b1;
        div_start_ready_i = 1'b1;
        step();
        set_req(6);
        step();
        req_valid_i        = 1'b0;
        div_start_ready_i  = 1'b1;
        div_finish_valid_i = 1'b1;
        rsp_ready_i        = 1'b0;
        held_res           = {$urandom, $urandom};
        div_res_i          = held_res;
        div_fflags_i       = 5'h1A;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_tag", 64'(rsp_tag_o), 64'(5));
            chk("bp_rsp_res", rsp_res_o, held_res);
        end
        rsp_ready_i = 1'b1;
        drain();

        // Flush with three queued and one in flight.
        base = got_q.size();
        set_req(10);
        req_valid_i = 1'b1;
        div_start_ready_i = 1'b0;
        step();
        set_req(11);
        div_start_ready_i = 1'b1;
        step();
        div_start_ready_i = 1'b0;
        set_req(12);
        step();
        set_req(13);
        step();
        chk("flush_pre_count", 64'(count_o), 64'(3));
        set_req(14);
        flush_i            = 1'b1;
        div_finish_valid_i = 1'b1;
        rsp_ready_i        = 1'b1;
        step();
        flush_i            = 1'b0;
        req_valid_i        = 1'b0;
        div_finish_valid_i = 1'b0;
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_busy", 64'(busy_o), 64'(0));
        step();
        chk("flush_no_rsp", 64'(got_q.size()), 64'(base));

        // Asynchronous reset between edges while an op is in flight.
        set_req(1);
        req_valid_i = 1'b1;
        div_start_ready_i = 1'b1;
        step();
        set_req(2);
        step();
        req_valid_i        = 1'b0;
        div_start_ready_i  = 1'b0;
        div_finish_valid_i = 1'b1;
        rsp_ready_i        = 1'b1;
        chk("arst_pre_busy", 64'(busy_o), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        mq.delete();
        inflight = 1'b0;
        div_finish_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(7);
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
